// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - BCD_NIBBLE : width of one packed BCD digit
//   - state_t    : converter FSM encoding (2'd3 is unused and recovers to IDLE)
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_RSVD  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble nibble corrector: adds 3 to a BCD digit that is
// 5 or more so that the following left shift carries correctly into the next
// decimal digit. The result is confined to 4 bits; nothing carries out.
// Ports:
//   nibble_in  in  4  BCD digit before correction
//   nibble_out out 4  corrected digit
// ---------------------------------------------------------------------------
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] nibble_in,
  output logic [BCD_NIBBLE-1:0] nibble_out
);

  assign nibble_out = (nibble_in >= 4'd5) ? (nibble_in + 4'd3) : nibble_in;

endmodule

// File: rtl/bin8_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin8_to_bcd_seq
// Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter. Takes
// the 8-bit product of the 4x4 multiplier and produces packed hundreds/tens/
// ones digits for the display stage. One conversion in flight at a time.
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          asynchronous active-high reset
//   start  in   1          conversion request, only honoured in IDLE
//   bin    in   WIDTH      binary value, captured on the accept edge
//   busy   out  1          high while shifting
//   done   out  1          one-cycle pulse, bcd valid from this cycle on
//   bcd    out  4*DIGITS   [11:8] hundreds, [7:4] tens, [3:0] ones
// ---------------------------------------------------------------------------
module bin8_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           bin,
  output logic                       busy,
  output logic                       done,
  output logic [BCD_NIBBLE*DIGITS-1:0] bcd
);

  localparam int BCD_W = BCD_NIBBLE * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t            state;
  state_t            state_next;
  logic [SR_W-1:0]   shift_reg;
  logic [SR_W-1:0]   corrected;
  logic [SR_W-1:0]   shifted;
  logic [CNT_W-1:0]  count;
  logic              last_shift;

  // Per-digit add-3 correction; the binary part of the register passes as-is.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .nibble_in  (shift_reg[WIDTH + BCD_NIBBLE*i +: BCD_NIBBLE]),
      .nibble_out (corrected[WIDTH + BCD_NIBBLE*i +: BCD_NIBBLE])
    );
  end

  assign corrected[WIDTH-1:0] = shift_reg[WIDTH-1:0];
  assign shifted              = corrected << 1;

  // The shift taken while count is WIDTH-1 is the WIDTH-th and final one.
  assign last_shift = (count == LAST_CNT);

  // Next-state logic for the converter FSM.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_shift) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; busy/done are registered decodes of the next state so
  // they track the state exactly and can never be high together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_SHIFT);
      done  <= (state_next == ST_DONE);
    end
  end

  // Datapath: load on accept, correct-and-shift while busy, capture the
  // result only on the final shift so bcd holds steady during SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= {SR_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      bcd       <= {BCD_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= {{BCD_W{1'b0}}, bin};
            count     <= {CNT_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          shift_reg <= shifted;
          count     <= count + ONE_CNT;
          if (last_shift) begin
            bcd <= shifted[SR_W-1 -: BCD_W];
          end
        end
        default: begin
          shift_reg <= shift_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin8_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin8_to_bcd_seq
// Directed self-checking bench for bin8_to_bcd_seq. Expected BCD values come
// from hand-computed constants and a divide/modulo reference model.
// ---------------------------------------------------------------------------
module tb_bin8_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bin8_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One conversion; optionally pulses start with another value mid-SHIFT.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp,
                         input string tag, input bit disturb);
    int          edges;
    bit          stable;
    logic [11:0] held;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    held  = bcd;
    stable = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
    check({tag, " busy after accept"}, busy, 1);
    while (done !== 1'b1 && edges < 20) begin
      if (bcd !== held) stable = 1'b0;
      if (disturb && edges == 3) begin
        start = 1'b1;
        bin   = 8'd199;
      end else if (disturb && edges == 4) begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, " latency"}, edges, 9);
    check({tag, " bcd"}, bcd, exp);
    check({tag, " busy low in done"}, busy, 0);
    check({tag, " bcd stable in shift"}, stable, 1);
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " idle after done"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b_hist [40];
    bit d_hist [40];
    int first_done;
    int done_seen;

    // Reset state
    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset bcd", bcd, 12'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed values
    convert(8'd0,   12'h000, "zero",  1'b0);
    convert(8'd255, 12'h255, "max",   1'b0);
    convert(8'd225, 12'h225, "15x15", 1'b0);
    convert(8'd81,  12'h081, "81",    1'b0);
    convert(8'(9 * 7), 12'h063, "9x7", 1'b0);

    // start held high: 10-cycle busy/done pattern, each result 0x100
    @(negedge clk);
    bin   = 8'd100;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      b_hist[k] = busy;
      d_hist[k] = done;
      if (done) check("held start bcd", bcd, 12'h100);
    end
    start = 1'b0;
    first_done = -1;
    for (int k = 0; k < 40; k++) begin
      if (first_done < 0 && d_hist[k]) first_done = k;
    end
    check("held start first done", first_done, 8);
    if (first_done >= 0) begin
      for (int k = first_done + 1; k < 40; k++) begin
        check("held start busy pattern", b_hist[k], (((k - first_done) % 10) >= 2) ? 1 : 0);
        check("held start done pattern", d_hist[k], (((k - first_done) % 10) == 0) ? 1 : 0);
      end
    end
    @(negedge clk);
    check("held start released", busy, 0);

    // start while busy with a different value is ignored
    convert(8'd42, 12'h042, "ignore start", 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("no queued conversion", busy | done, 0);
    end

    // Asynchronous reset mid-SHIFT
    @(negedge clk);
    bin   = 8'd123;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst bcd", bcd, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("aborted conversion no done", done_seen, 0);
    convert(8'd123, 12'h123, "after reset", 1'b0);

    // Chained multiplier sweep against reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        convert(8'(a * b), ref_bcd(a * b), $sformatf("mul %0dx%0d", a, b), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
